// File: rtl/ncl_dualrail_sink_if.sv
// ncl_dualrail_sink_if: dual-rail word in, ko completion out, valid/ready word out plus count/error status
interface ncl_dualrail_sink_if #(parameter int DIGITS = 32);
    logic [DIGITS-1:0] rail1, rail0, out_data;
    logic ko, out_valid, out_ready, seq_err, illegal_err;
    logic [31:0] word_count;
    modport master(output rail1, rail0, out_ready, input ko, out_data, out_valid, word_count, seq_err, illegal_err);
    modport slave(input rail1, rail0, out_ready, output ko, out_data, out_valid, word_count, seq_err, illegal_err);
endinterface

// File: rtl/ncl_dualrail_sink.sv
// ncl_dualrail_sink: clk/init_n plus bus (rails in, ko out, out_data/out_valid/out_ready, word_count, seq_err, illegal_err) -- NCL dual-rail to binary receiver
module ncl_dualrail_sink #(
    parameter int DIGITS = 32,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYCLES = 2
) (
    input logic clk,
    input logic init_n,
    ncl_dualrail_sink_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] MAXC = CW'(STABLE_CYCLES - 1);
    typedef enum logic {WAIT_DATA, WAIT_NULL} state_t;
    state_t state, nxt;
    logic [SYNC_STAGES-1:0][DIGITS-1:0] s1, s0;
    logic [DIGITS-1:0] r1, r0, p1, p0, next_word;
    logic [CW-1:0] cnt;
    logic first_seen, same, stable, all_data, all_null, illegal, free, capture;
    assign r1 = s1[SYNC_STAGES-1];
    assign r0 = s0[SYNC_STAGES-1];
    assign bus.ko = state == WAIT_NULL;
    always_comb begin
        same = r1 == p1 && r0 == p0;
        stable = same && cnt >= MAXC;
        all_data = &(r1 ^ r0);
        all_null = ~|(r1 | r0);
        illegal = |(r1 & r0);
        free = !bus.out_valid || bus.out_ready;
        capture = state == WAIT_DATA && stable && all_data && free;
        next_word = bus.out_data + 1'b1;
        nxt = capture ? WAIT_NULL : (state == WAIT_NULL && stable && all_null) ? WAIT_DATA : state;
    end
    always_ff @(posedge clk)
        state <= !init_n ? WAIT_DATA : nxt;
    always_ff @(posedge clk) begin
        if (!init_n) begin
            s1 <= '0;
            s0 <= '0;
            p1 <= '0;
            p0 <= '0;
            cnt <= '0;
            first_seen <= 1'b0;
            bus.out_data <= '0;
            bus.out_valid <= 1'b0;
            bus.word_count <= '0;
            bus.seq_err <= 1'b0;
            bus.illegal_err <= 1'b0;
        end else begin
            s1 <= {s1[SYNC_STAGES-2:0], bus.rail1};
            s0 <= {s0[SYNC_STAGES-2:0], bus.rail0};
            p1 <= r1;
            p0 <= r0;
            cnt <= !same ? '0 : (cnt == MAXC ? cnt : cnt + 1'b1);
            if (capture) begin
                bus.out_data <= r1;
                bus.out_valid <= 1'b1;
                bus.word_count <= bus.word_count + 1'b1;
                bus.seq_err <= bus.seq_err | (first_seen && r1 != next_word);
                first_seen <= 1'b1;
            end else if (bus.out_ready)
                bus.out_valid <= 1'b0;
            if (stable && illegal)
                bus.illegal_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ncl_dualrail_sink.sv
// tb_ncl_dualrail_sink: directed and randomized check of ncl_dualrail_sink against a word-level model
module tb_ncl_dualrail_sink;
    logic clk = 1'b0;
    logic init_n = 1'b0;
    always #5 clk = ~clk;
    ncl_dualrail_sink_if #(.DIGITS(32)) bus();
    ncl_dualrail_sink #(.DIGITS(32), .SYNC_STAGES(2), .STABLE_CYCLES(2)) dut(.clk(clk), .init_n(init_n), .bus(bus.slave));
    int passed = 0;
    int total = 0;
    logic [31:0] m_last, m_cnt;
    logic m_first, m_seq, m_ill;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        bus.rail1 = a;
        bus.rail0 = b;
    endtask
    task automatic model_reset();
        m_last = '0;
        m_cnt = '0;
        m_first = 1'b0;
        m_seq = 1'b0;
        m_ill = 1'b0;
    endtask
    task automatic model_capture(input logic [31:0] w);
        if (m_first && w != m_last + 32'd1) m_seq = 1'b1;
        m_first = 1'b1;
        m_last = w;
        m_cnt = m_cnt + 32'd1;
    endtask
    task automatic wait_ko(input logic lvl, output int n);
        n = 0;
        while (bus.ko !== lvl && n < 100) begin
            step(1);
            n++;
        end
    endtask
    task automatic check_cleared(input string tag);
        chk({tag, "_ko"}, bus.ko, 0);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_data"}, bus.out_data, 0);
        chk({tag, "_count"}, bus.word_count, 0);
        chk({tag, "_seq"}, bus.seq_err, 0);
        chk({tag, "_ill"}, bus.illegal_err, 0);
    endtask
    task automatic do_reset();
        init_n = 1'b0;
        step(1);
        check_cleared("reset");
        init_n = 1'b1;
        model_reset();
    endtask
    task automatic send_data(input logic [31:0] w, input bit lat);
        int n;
        drive(w, ~w);
        wait_ko(1'b1, n);
        chk("ko_rise", bus.ko, 1);
        if (lat) chk("latency_ge5", n >= 5, 1);
        model_capture(w);
        chk("data", bus.out_data, w);
        chk("valid", bus.out_valid, 1);
        chk("count", bus.word_count, m_cnt);
        chk("seq_err", bus.seq_err, m_seq);
        chk("illegal_err", bus.illegal_err, m_ill);
    endtask
    task automatic send_null();
        int n;
        drive('0, '0);
        wait_ko(1'b0, n);
        chk("ko_fall", bus.ko, 0);
    endtask
    initial begin
        logic [31:0] w, a, b;
        drive('0, '0);
        bus.out_ready = 1'b1;
        model_reset();
        step(3);
        check_cleared("init");
        init_n = 1'b1;
        step(2);
        send_data(32'h5, 1);
        send_null();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send_data(i, 0);
            send_null();
        end
        chk("count10", bus.word_count, 10);
        chk("seq_clean", bus.seq_err, 0);
        do_reset();
        send_data(32'hFFFF_FFFF, 0);
        send_null();
        send_data(32'h0, 0);
        send_null();
        chk("wrap_seq", bus.seq_err, 0);
        do_reset();
        send_data(32'd3, 0);
        send_null();
        send_data(32'd4, 0);
        send_null();
        send_data(32'd6, 0);
        send_null();
        chk("gap_seq", bus.seq_err, 1);
        send_data(32'd7, 0);
        send_null();
        chk("seq_sticky", bus.seq_err, 1);
        step(2);
        drive(32'h1234, ~32'h1234);
        step(1);
        drive('0, '0);
        step(10);
        chk("glitch_ko", bus.ko, 0);
        chk("glitch_count", bus.word_count, m_cnt);
        a = $urandom;
        b = a + 32'd1;
        bus.out_ready = 1'b0;
        send_data(a, 0);
        send_null();
        drive(b, ~b);
        step(10);
        chk("bp_ko", bus.ko, 0);
        chk("bp_data", bus.out_data, a);
        chk("bp_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        step(1);
        model_capture(b);
        chk("bp_ko_rise", bus.ko, 1);
        chk("bp_data2", bus.out_data, b);
        chk("bp_valid2", bus.out_valid, 1);
        chk("bp_count", bus.word_count, m_cnt);
        send_null();
        w = b + 32'd1;
        drive(w | 32'h80, ~w | 32'h80);
        step(10);
        m_ill = 1'b1;
        chk("ill_flag", bus.illegal_err, 1);
        chk("ill_ko", bus.ko, 0);
        chk("ill_count", bus.word_count, m_cnt);
        send_data(w | 32'h80, 0);
        send_null();
        do_reset();
        w = $urandom;
        for (int i = 0; i < 12; i++) begin
            step($urandom_range(0, 3));
            send_data(w, 0);
            send_null();
            w = ($urandom_range(0, 3) == 0) ? $urandom : w + 32'd1;
        end
        bus.out_ready = 1'b0;
        w = $urandom;
        send_data(w, 0);
        init_n = 1'b0;
        step(1);
        check_cleared("mid");
        init_n = 1'b1;
        model_reset();
        bus.out_ready = 1'b1;
        begin
            int n;
            wait_ko(1'b1, n);
        end
        model_capture(w);
        chk("recap_ko", bus.ko, 1);
        chk("recap_data", bus.out_data, w);
        chk("recap_count", bus.word_count, m_cnt);
        chk("recap_seq", bus.seq_err, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ncl_dualrail_sink.md
Name: ncl_dualrail_sink

Overview:
- Clocked receiver for the asynchronous NCL dual-rail word emitted by the digit-pipelined counters, i.e. the consuming end of the sum/completion interface.
- Synchronises the rails into `clk`, detects DATA and NULL wavefront completeness, and converts each DATA wavefront to a binary word with a valid/ready handshake.
- Drives the NCL completion signal back to the producer.
- Checks that successive words count up by one; used as the bench-side or on-chip consumer of counter sums.

Parameters:
- DIGITS, 32, number of dual-rail digits (binary word width).
- SYNC_STAGES, 2, flip-flop synchroniser depth per rail (≥2).
- STABLE_CYCLES, 2, consecutive identical synchronised samples required before a wavefront is accepted (≥1).

Ports:
- clk  in  1  sole clock.
- init_n  in  1  synchronous active-low reset.
- rail1  in  DIGITS  rail-1 of each digit (asynchronous to `clk`).
- rail0  in  DIGITS  rail-0 of each digit (asynchronous to `clk`).
- ko  out  1  completion to producer: 1 = DATA absorbed, send NULL; 0 = NULL absorbed, send DATA.
- out_data  out  DIGITS  binary word, bit i = rail1[i] of the captured wavefront.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  downstream accepts out_data when out_valid&&out_ready at a clk edge.
- word_count  out  32  DATA wavefronts captured since reset, wraps 2^32-1 -> 0.
- seq_err  out  1  sticky: a captured word ≠ previous+1 mod 2^DIGITS.
- illegal_err  out  1  sticky: some digit sampled with both rails 1.

Behaviour:
- Reset: init_n low at a clk edge clears synchroniser flops, stability counter, ko, out_valid, out_data, word_count, seq_err, illegal_err and first_seen, and forces state WAIT_DATA. This applies equally mid-handshake; the producer sees ko=0, and any in-flight DATA is then handled as a fresh wavefront.
- Synchroniser: each rail bit passes through SYNC_STAGES flops; all decoding uses the last stage only. Input to ko latency is therefore SYNC_STAGES + STABLE_CYCLES + 1 cycles minimum.
- Digit classification per synchronised sample:
  - NULL: both rails 0.
  - DATA: exactly one rail 1.
  - ILLEGAL: both rails 1.
  - Word complete-DATA: all digits DATA.
  - Word complete-NULL: all digits NULL.
- Stability: a counter increments while the synchronised vector equals the previous cycle's vector and resets to 0 on any change. A wavefront is accepted only when the counter ≥ STABLE_CYCLES-1.
- FSM state WAIT_DATA (ko=0):
  - If a stable complete-DATA word is present and the holding register is free (out_valid=0, or out_valid&&out_ready this cycle), then on the next edge:
    - load out_data;
    - set out_valid=1 and ko=1;
    - increment word_count;
    - if first_seen and out_data_new ≠ last+1, set seq_err; then set first_seen;
    - go to WAIT_NULL.
  - If the holding register is not free, stay in WAIT_DATA with ko=0. This is backpressure: the producer stalls holding DATA.
  - Partial or unstable words: no action.
- FSM state WAIT_NULL (ko=1): a stable complete-NULL word sets ko=0 and returns to WAIT_DATA. Partial NULL (some digits still DATA) holds the state.
- ILLEGAL in any stable sample, in either state, sets illegal_err. The word is never captured and the state does not change.
- Output handshake: out_valid clears on an edge where out_valid&&out_ready, unless a capture occurs on the same edge, in which case out_valid stays 1 with the new data. out_data is stable while out_valid=1 and out_ready=0.
- Sequence check wraps: all-ones followed by 0 is legal.
- Rails changing during the stability window restart the window. Glitches shorter than STABLE_CYCLES samples are never captured.

Test Plan:
- Reset then DATA 0x00000005 (rail1=0x5, rail0=~0x5): ko rises after ≥ SYNC_STAGES+STABLE_CYCLES+1 cycles; out_data=0x5; out_valid=1; word_count=1. Then all-NULL: ko falls.
- Counter sequence 0,1,2,…,9 with out_ready=1 -> ten captures, word_count=10, seq_err=0. Then sequence 0xFFFFFFFF,0x00000000 -> seq_err stays 0.
- Sequence 3,4,6 -> seq_err=1 after the third capture and stays 1 until init_n low.
- out_ready=0 after the first word; second DATA presented after NULL -> ko stays 0 and out_data holds the first word. Raise out_ready -> the second word is captured next cycle and ko rises.
- Digit 7 with both rails 1 while the others are DATA -> illegal_err=1, no capture, ko=0. Fix digit 7 to rail1 -> normal capture.
- init_n low while ko=1 and out_valid=1 -> next cycle ko=0, out_valid=0, word_count=0, errors cleared. The held DATA is then recaptured as the first word, with no seq_err.
